// File: rtl/seg7_pkg.sv
// Shared constants for the front-panel seven-segment driver.
// Segment patterns are ordered {g,f,e,d,c,b,a}, logical (active-high) polarity.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to seven-segment pattern; non-decimal nibbles show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous value updates,
// leading-zero blanking, fixed decimal point and whole-display blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int DP_POS       = 2,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [15:0]   disp_q, disp_d;
    logic [BW-1:0] fcnt_q, fcnt_d;
    logic          phase_on_q, phase_on_d;
    logic          blink_q;
    logic          wrap_q, wrap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q;

    logic          presc_tc, boundary, blink_fall;
    logic [3:0]    cur_nib;
    logic [6:0]    seg_raw;
    logic [NUM_DIGITS-1:0] lz_vec;
    logic          lz_run;

    bcd_to_seg7 u_dec (
        .nib (cur_nib),
        .seg (seg_raw)
    );

    always_comb begin
        presc_tc   = (presc_q == PW'(REFRESH_DIV - 1));
        boundary   = presc_tc && (dig_q == 2'd3);
        blink_fall = blink_q && !blink;
        presc_d    = presc_tc ? '0 : presc_q + 1'b1;
        dig_d      = presc_tc ? dig_q + 2'd1 : dig_q;
        wrap_d     = boundary;

        // A load coinciding with the boundary bypasses the pending register.
        pend_d       = load ? bcd : pend_q;
        pend_valid_d = pend_valid_q | load;
        disp_d       = disp_q;
        if (boundary && (pend_valid_q || load)) begin
            disp_d       = load ? bcd : pend_q;
            pend_valid_d = 1'b0;
        end

        fcnt_d     = fcnt_q;
        phase_on_d = phase_on_q;
        if (blink_fall) begin
            fcnt_d     = '0;
            phase_on_d = 1'b1;
        end else if (boundary) begin
            if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
                fcnt_d     = '0;
                phase_on_d = !phase_on_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Blanking runs down from the top digit and stops at the first nonzero nibble or DP_POS.
    always_comb begin
        lz_vec = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_run    = lz_run && (i > DP_POS) && (disp_q[i*4 +: 4] == 4'd0);
            lz_vec[i] = lz_run;
        end
    end

    always_comb begin
        cur_nib = disp_q[{dig_q, 2'b00} +: 4];
        an_d    = (blink && !phase_on_q) ? 4'b0000 : (4'b0001 << dig_q);
        seg_d   = (blank_lz && lz_vec[dig_q]) ? SEG_OFF : seg_raw;
        dp_d    = (int'(dig_q) == DP_POS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            dig_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            fcnt_q       <= '0;
            phase_on_q   <= 1'b1;
            blink_q      <= 1'b0;
            wrap_q       <= 1'b0;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            dig_q        <= dig_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            fcnt_q       <= fcnt_d;
            phase_on_q   <= phase_on_d;
            blink_q      <= blink;
            wrap_q       <= wrap_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= wrap_q;
        end
    end

    assign an         = ACTIVE_LOW ? ~an_q  : an_q;
    assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dp         = ACTIVE_LOW ? ~dp_q  : dp_q;
    assign frame_done = frame_done_q;

endmodule
